// File: rtl/xbus_mem_arbiter.sv
// xbus_mem_arbiter: round-robin sharing of one xbus slave port
// between NUM_MASTERS requesters, with a per-transaction watchdog.
module xbus_mem_arbiter #(
   parameter int NUM_MASTERS = 4,
   parameter int TIMEOUT     = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_MASTERS-1:0]    m_req,
   input  logic [NUM_MASTERS*32-1:0] m_addr,
   input  logic [NUM_MASTERS*32-1:0] m_data,
   input  logic [NUM_MASTERS-1:0]    m_rnw,
   input  logic [NUM_MASTERS*4-1:0]  m_be,
   output logic [NUM_MASTERS-1:0]    m_ack,
   output logic [NUM_MASTERS-1:0]    m_err,
   output logic [31:0]               m_rdata,
   output logic                      xbs_select,
   output logic [31:0]               xbs_addr,
   output logic [31:0]               xbs_data,
   output logic                      xbs_rnw,
   output logic [3:0]                xbs_be,
   input  logic                      sl_ack,
   input  logic [31:0]               sl_data
);

   localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int WW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [GW-1:0]          grant_q, grant_d;
   logic [GW-1:0]          last_q, last_d;
   logic [WW-1:0]          wdog_q, wdog_d;
   logic                   sel_q, sel_d;
   logic [31:0]            addr_q, addr_d;
   logic [31:0]            data_q, data_d;
   logic                   rnw_q, rnw_d;
   logic [3:0]             be_q, be_d;
   logic [NUM_MASTERS-1:0] ack_q, ack_d;
   logic [NUM_MASTERS-1:0] err_q, err_d;
   logic [31:0]            rdata_q, rdata_d;

   logic                   found;
   logic [GW-1:0]          pick;
   logic [GW-1:0]          idx;
   logic [31:0]            req_addr;
   logic [31:0]            req_data;
   logic                   req_rnw;
   logic [3:0]             req_be;

   // Round-robin search starting after the last served master, then
   // mux out the winner's request fields.
   always_comb begin
      found    = 1'b0;
      pick     = '0;
      idx      = '0;
      req_addr = '0;
      req_data = '0;
      req_rnw  = 1'b1;
      req_be   = '0;
      for (int k = 1; k <= NUM_MASTERS; k++) begin
         idx = GW'((int'(last_q) + k) % NUM_MASTERS);
         if (!found && m_req[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (pick == GW'(i)) begin
            req_addr = m_addr[32*i +: 32];
            req_data = m_data[32*i +: 32];
            req_rnw  = m_rnw[i];
            req_be   = m_be[4*i +: 4];
         end
      end
   end

   // Transaction FSM: next state and registered outputs.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      wdog_d  = wdog_q;
      sel_d   = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      rnw_d   = rnw_q;
      be_d    = be_q;
      ack_d   = '0;
      err_d   = '0;
      rdata_d = rdata_q;
      unique case (state_q)
         S_IDLE: begin
            if (found) begin
               grant_d = pick;
               addr_d  = req_addr;
               data_d  = req_data;
               rnw_d   = req_rnw;
               be_d    = req_be;
               sel_d   = 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            wdog_d  = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (sl_ack) begin
               ack_d = NUM_MASTERS'(1) << grant_q;
               if (rnw_q) begin
                  rdata_d = sl_data;
               end
               last_d  = grant_q;
               state_d = S_DONE;
            end else if (wdog_q == WW'(TIMEOUT - 1)) begin
               ack_d = NUM_MASTERS'(1) << grant_q;
               err_d = NUM_MASTERS'(1) << grant_q;
               if (rnw_q) begin
                  rdata_d = '0;
               end
               last_d  = grant_q;
               state_d = S_DONE;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         last_q  <= GW'(NUM_MASTERS - 1);
         wdog_q  <= '0;
         sel_q   <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         rnw_q   <= 1'b1;
         be_q    <= '0;
         ack_q   <= '0;
         err_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         wdog_q  <= wdog_d;
         sel_q   <= sel_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         rnw_q   <= rnw_d;
         be_q    <= be_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   assign m_ack      = ack_q;
   assign m_err      = err_q;
   assign m_rdata    = rdata_q;
   assign xbs_select = sel_q;
   assign xbs_addr   = addr_q;
   assign xbs_data   = data_q;
   assign xbs_rnw    = rnw_q;
   assign xbs_be     = be_q;

endmodule

// File: tb/tb_xbus_mem_arbiter.sv
// tb_xbus_mem_arbiter: randomized and directed checks of the arbiter
// against a transaction-level round-robin and memory model.
module tb_xbus_mem_arbiter;

   localparam int NM = 4;
   localparam int TO = 64;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [NM-1:0]   m_req = '0;
   logic [NM*32-1:0] m_addr = '0;
   logic [NM*32-1:0] m_data = '0;
   logic [NM-1:0]   m_rnw = '1;
   logic [NM*4-1:0] m_be = '0;
   logic [NM-1:0]   m_ack;
   logic [NM-1:0]   m_err;
   logic [31:0]     m_rdata;
   logic            xbs_select;
   logic [31:0]     xbs_addr;
   logic [31:0]     xbs_data;
   logic            xbs_rnw;
   logic [3:0]      xbs_be;
   logic            sl_ack = 1'b0;
   logic [31:0]     sl_data = '0;

   int errors = 0;
   int checks = 0;

   xbus_mem_arbiter #(.NUM_MASTERS(NM), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .m_req(m_req), .m_addr(m_addr), .m_data(m_data),
      .m_rnw(m_rnw), .m_be(m_be),
      .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
      .xbs_select(xbs_select), .xbs_addr(xbs_addr),
      .xbs_data(xbs_data), .xbs_rnw(xbs_rnw), .xbs_be(xbs_be),
      .sl_ack(sl_ack), .sl_data(sl_data)
   );

   always #5 clk = ~clk;

   // memory seen by the slave (driven by DUT outputs) and the model
   bit [31:0] smem [bit [31:0]];
   bit [31:0] mmem [bit [31:0]];
   bit        slave_en = 1'b1;
   bit        stray_ack = 1'b0;
   int        fix_delay = 0;
   int        sel_count = 0;
   bit        s_pend = 1'b0;
   int        s_cnt = 0;
   logic [31:0] c_addr, c_data, s_rd;
   logic        c_rnw;
   logic [3:0]  c_be;

   int          mlast;
   logic [31:0] exp_rdata;
   int          order[$];
   int          first_lat;

   function automatic bit [31:0] merge(bit [31:0] old, logic [31:0] d,
                                       logic [3:0] be);
      bit [31:0] r = old;
      for (int b = 0; b < 4; b++)
         if (be[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   function automatic bit [31:0] mrd(bit [31:0] a);
      return mmem.exists(a) ? mmem[a] : 32'h0;
   endfunction

   function automatic int rr_pick(int last, logic [NM-1:0] req);
      for (int k = 1; k <= NM; k++) begin
         int i = (last + k) % NM;
         if (req[i] === 1'b1) return i;
      end
      return -1;
   endfunction

   // behavioural memory controller responding to xbs_select
   always @(negedge clk) begin
      if (rst) begin
         s_pend = 1'b0;
         sl_ack = 1'b0;
      end else begin
         sl_ack = 1'b0;
         sl_data = $urandom;
         if (stray_ack) begin
            sl_ack = 1'b1;
            stray_ack = 1'b0;
         end
         if (s_pend) begin
            checks++;
            if (xbs_addr !== c_addr || xbs_data !== c_data ||
                xbs_rnw !== c_rnw || xbs_be !== c_be) begin
               errors++;
               $display("FAIL xbs_hold: got %h %h %b %h want %h %h %b %h",
                        xbs_addr, xbs_data, xbs_rnw, xbs_be,
                        c_addr, c_data, c_rnw, c_be);
            end
            s_cnt--;
            if (s_cnt <= 0) begin
               s_pend = 1'b0;
               if (slave_en) begin
                  sl_ack = 1'b1;
                  sl_data = s_rd;
               end
            end
         end
         if (xbs_select === 1'b1) begin
            sel_count++;
            s_pend = 1'b1;
            s_cnt = (fix_delay > 0) ? fix_delay : int'($urandom_range(1, 5));
            c_addr = xbs_addr;
            c_data = xbs_data;
            c_rnw = xbs_rnw;
            c_be = xbs_be;
            if (xbs_rnw) begin
               s_rd = smem.exists(xbs_addr) ? smem[xbs_addr] : 32'h0;
            end else begin
               smem[xbs_addr] = merge(smem.exists(xbs_addr) ?
                                      smem[xbs_addr] : 32'h0,
                                      xbs_data, xbs_be);
               s_rd = $urandom;
            end
         end
      end
   end

   task automatic set_txn(int i, logic [31:0] a, logic [31:0] d,
                          logic rnw, logic [3:0] be);
      m_addr[32*i +: 32] = a;
      m_data[32*i +: 32] = d;
      m_rnw[i] = rnw;
      m_be[4*i +: 4] = be;
   endtask

   task automatic rand_txn(int i);
      set_txn(i, 32'($urandom_range(0, 7)), $urandom,
              1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
   endtask

   task automatic check_reset_values(string tag);
      checks++;
      if (xbs_select !== 1'b0 || xbs_addr !== 32'h0 || xbs_data !== 32'h0) begin
         errors++;
         $display("FAIL %s_xbs: sel=%b addr=%h data=%h want 0 0 0",
                  tag, xbs_select, xbs_addr, xbs_data);
      end
      checks++;
      if (xbs_rnw !== 1'b1 || xbs_be !== 4'h0) begin
         errors++;
         $display("FAIL %s_rnw_be: rnw=%b be=%h want 1 0", tag, xbs_rnw, xbs_be);
      end
      checks++;
      if (m_ack !== '0 || m_err !== '0) begin
         errors++;
         $display("FAIL %s_ack: ack=%b err=%b want 0 0", tag, m_ack, m_err);
      end
      checks++;
      if (m_rdata !== 32'h0) begin
         errors++;
         $display("FAIL %s_rdata: got %h want 0", tag, m_rdata);
      end
   endtask

   // requests cN transactions from master N; checks every completion
   task automatic run_batch(input int c0, input int c1, input int c2,
                            input int c3, input bit rnd, input string tag);
      int cnt[NM];
      int total;
      int budget;
      int sel0;
      int n;
      int e;
      bit [31:0] a;
      cnt = '{c0, c1, c2, c3};
      @(negedge clk);
      total = 0;
      n = 0;
      order.delete();
      first_lat = -1;
      sel0 = sel_count;
      for (int i = 0; i < NM; i++) begin
         if (cnt[i] > 0) begin
            if (rnd) rand_txn(i);
            m_req[i] = 1'b1;
            total += cnt[i];
         end
      end
      budget = total * (TO + 20);
      for (int cyc = 1; total > 0 && cyc <= budget; cyc++) begin
         @(negedge clk);
         checks++;
         if ((m_err & ~m_ack) !== '0) begin
            errors++;
            $display("FAIL %s_err_no_ack: err=%b ack=%b", tag, m_err, m_ack);
         end
         if (m_ack !== '0) begin
            e = rr_pick(mlast, m_req);
            if (e < 0) e = 0;
            checks++;
            if (m_ack !== (4'b0001 << e)) begin
               errors++;
               $display("FAIL %s_grant: ack=%b want master %0d", tag, m_ack, e);
            end
            checks++;
            if (m_err !== '0) begin
               errors++;
               $display("FAIL %s_err: got %b want 0", tag, m_err);
            end
            a = m_addr[32*e +: 32];
            if (m_rnw[e]) exp_rdata = mrd(a);
            else mmem[a] = merge(mrd(a), m_data[32*e +: 32], m_be[4*e +: 4]);
            checks++;
            if (m_rdata !== exp_rdata) begin
               errors++;
               $display("FAIL %s_rdata: got %h want %h (master %0d rnw %b)",
                        tag, m_rdata, exp_rdata, e, m_rnw[e]);
            end
            if (first_lat < 0) first_lat = cyc;
            order.push_back(e);
            mlast = e;
            n++;
            total--;
            cnt[e]--;
            if (cnt[e] <= 0) m_req[e] = 1'b0;
            else if (rnd) rand_txn(e);
         end
      end
      checks++;
      if (total != 0) begin
         errors++;
         $display("FAIL %s_timeout: %0d transactions outstanding want 0", tag, total);
         m_req = '0;
      end
      checks++;
      if (sel_count - sel0 != n) begin
         errors++;
         $display("FAIL %s_selects: got %0d want %0d", tag, sel_count - sel0, n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      m_req = '0;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      rst = 1'b0;
      mlast = NM - 1;
      exp_rdata = 32'h0;
   endtask

   task automatic test_round_robin();
      int want[5] = '{0, 1, 2, 3, 0};
      run_batch(2, 1, 1, 1, 1'b1, "rr");
      checks++;
      if (order.size() != 5) begin
         errors++;
         $display("FAIL rr_count: got %0d acks want 5", order.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (order[i] != want[i]) begin
               errors++;
               $display("FAIL rr_order[%0d]: got %0d want %0d", i, order[i], want[i]);
            end
         end
      end
   endtask

   task automatic test_write_read();
      fix_delay = 3;
      set_txn(0, 32'h10, 32'hA5A5_1234, 1'b0, 4'hF);
      run_batch(1, 0, 0, 0, 1'b0, "wr");
      checks++;
      if (first_lat != 5) begin
         errors++;
         $display("FAIL wr_latency: got %0d want 5", first_lat);
      end
      set_txn(0, 32'h10, 32'h0, 1'b1, 4'hF);
      run_batch(1, 0, 0, 0, 1'b0, "rd");
      checks++;
      if (m_rdata !== 32'hA5A5_1234) begin
         errors++;
         $display("FAIL rd_data: got %h want a5a51234", m_rdata);
      end
      checks++;
      if (first_lat != 5) begin
         errors++;
         $display("FAIL rd_latency: got %0d want 5", first_lat);
      end
      fix_delay = 0;
   endtask

   task automatic test_priority();
      set_txn(2, 32'h5, 32'h1234_5678, 1'b0, 4'hF);
      run_batch(0, 0, 1, 0, 1'b0, "prio_pre");
      run_batch(0, 1, 0, 1, 1'b1, "prio");
      checks++;
      if (order.size() != 2 || order[0] != 3 || order[1] != 1) begin
         errors++;
         $display("FAIL prio_order: got %p want 3 then 1", order);
      end
   endtask

   task automatic test_byte_enable();
      set_txn(2, 32'h20, 32'hFFFF_FFFF, 1'b0, 4'hF);
      run_batch(0, 0, 1, 0, 1'b0, "be_w1");
      set_txn(2, 32'h20, 32'h0000_0000, 1'b0, 4'h5);
      run_batch(0, 0, 1, 0, 1'b0, "be_w2");
      set_txn(2, 32'h20, 32'h0, 1'b1, 4'hF);
      run_batch(0, 0, 1, 0, 1'b0, "be_rd");
      checks++;
      if (m_rdata !== 32'hFF00_FF00) begin
         errors++;
         $display("FAIL be_merge: got %h want ff00ff00", m_rdata);
      end
   endtask

   task automatic test_random();
      int c[NM];
      for (int r = 0; r < 25; r++) begin
         for (int i = 0; i < NM; i++) c[i] = int'($urandom_range(0, 2));
         if (c[0] + c[1] + c[2] + c[3] == 0) c[r % NM] = 1;
         run_batch(c[0], c[1], c[2], c[3], 1'b1, "rand");
      end
   endtask

   task automatic test_timeout();
      int lat;
      slave_en = 1'b0;
      fix_delay = 1;
      set_txn(1, 32'h30, 32'h0, 1'b1, 4'hF);
      @(negedge clk);
      m_req[1] = 1'b1;
      lat = -1;
      for (int cyc = 1; cyc <= TO + 20; cyc++) begin
         @(negedge clk);
         if (m_ack !== '0) begin
            lat = cyc;
            break;
         end
      end
      checks++;
      if (lat != TO + 2) begin
         errors++;
         $display("FAIL to_latency: got %0d want %0d", lat, TO + 2);
      end
      checks++;
      if (m_ack !== 4'b0010 || m_err !== 4'b0010) begin
         errors++;
         $display("FAIL to_flags: ack=%b err=%b want 0010 0010", m_ack, m_err);
      end
      checks++;
      if (m_rdata !== 32'h0) begin
         errors++;
         $display("FAIL to_rdata: got %h want 0", m_rdata);
      end
      m_req[1] = 1'b0;
      mlast = 1;
      exp_rdata = 32'h0;
      @(negedge clk);
      stray_ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (m_ack !== '0 || m_err !== '0 || xbs_select !== 1'b0) begin
            errors++;
            $display("FAIL late_ack: ack=%b err=%b sel=%b want 0 0 0",
                     m_ack, m_err, xbs_select);
         end
      end
      slave_en = 1'b1;
      fix_delay = 0;
      run_batch(0, 1, 1, 0, 1'b1, "after_to");
   endtask

   task automatic test_reset_in_wait();
      set_txn(2, 32'h6, 32'h0BAD_F00D, 1'b0, 4'hF);
      run_batch(0, 0, 1, 0, 1'b0, "rw_pre");
      slave_en = 1'b0;
      fix_delay = 1;
      set_txn(2, 32'h40, 32'hDEAD_BEEF, 1'b0, 4'hF);
      @(negedge clk);
      m_req[2] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (m_ack !== '0) begin
            errors++;
            $display("FAIL rw_early_ack: got %b want 0", m_ack);
         end
      end
      rst = 1'b1;
      @(negedge clk);
      check_reset_values("rst_wait");
      rst = 1'b0;
      m_req = '0;
      mlast = NM - 1;
      exp_rdata = 32'h0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (m_ack !== '0 || xbs_select !== 1'b0) begin
            errors++;
            $display("FAIL rw_abandon: ack=%b sel=%b want 0 0", m_ack, xbs_select);
         end
      end
      slave_en = 1'b1;
      fix_delay = 0;
      run_batch(1, 0, 0, 1, 1'b1, "rw_post");
      checks++;
      if (order.size() < 1 || order[0] != 0) begin
         errors++;
         $display("FAIL rw_first_grant: got %p want master 0 first", order);
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      test_reset();
      test_round_robin();
      test_write_read();
      test_priority();
      test_byte_enable();
      test_random();
      test_timeout();
      test_reset_in_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
